// File: rtl/x_ramb4_bist_pkg.sv
// Shared types and the March C- element table for the 256x16 block RAM self-test.
package x_ramb4_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Background code; replicated across the data width by the user.
  typedef enum logic {
    BG0 = 1'b0,
    BG1 = 1'b1
  } bg_e;

  typedef struct packed {
    logic up;
    logic two_ops;
    op_e  op_a;
    bg_e  bg_a;
    op_e  op_b;
    bg_e  bg_b;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(elem_e e);
    elem_cfg_t c;
    c = '{up: 1'b1, two_ops: 1'b0, op_a: OP_WR, bg_a: BG0, op_b: OP_WR, bg_b: BG0};
    case (e)
      M0:      c = '{up: 1'b1, two_ops: 1'b0, op_a: OP_WR, bg_a: BG0, op_b: OP_WR, bg_b: BG0};
      M1:      c = '{up: 1'b1, two_ops: 1'b1, op_a: OP_RD, bg_a: BG0, op_b: OP_WR, bg_b: BG1};
      M2:      c = '{up: 1'b1, two_ops: 1'b1, op_a: OP_RD, bg_a: BG1, op_b: OP_WR, bg_b: BG0};
      M3:      c = '{up: 1'b0, two_ops: 1'b1, op_a: OP_RD, bg_a: BG0, op_b: OP_WR, bg_b: BG1};
      M4:      c = '{up: 1'b0, two_ops: 1'b1, op_a: OP_RD, bg_a: BG1, op_b: OP_WR, bg_b: BG0};
      M5:      c = '{up: 1'b1, two_ops: 1'b0, op_a: OP_RD, bg_a: BG0, op_b: OP_RD, bg_b: BG0};
      default: c = '{up: 1'b1, two_ops: 1'b0, op_a: OP_WR, bg_a: BG0, op_b: OP_WR, bg_b: BG0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/x_ramb4_bist_chk.sv
// One-stage read-compare pipeline with first-failure capture.
module x_ramb4_bist_chk
  import x_ramb4_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_i,
  input  logic              issue_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] ram_do_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              mismatch_s;

  // RAM_DO belongs to the read issued one cycle earlier; only the first miss is kept.
  assign mismatch_s = vld_q & ~fail_q & (ram_do_i != exp_q);

  // Pipeline the pending read and latch the first failing location.
  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      vld_q       <= 1'b0;
      exp_q       <= {DATA_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      fail_q      <= 1'b0;
      fail_addr_q <= {ADDR_W{1'b0}};
      fail_data_q <= {DATA_W{1'b0}};
    end else begin
      vld_q  <= issue_i;
      exp_q  <= exp_i;
      addr_q <= addr_i;
      if (mismatch_s) begin
        fail_q      <= 1'b1;
        fail_addr_q <= addr_q;
        fail_data_q <= ram_do_i;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: rtl/x_ramb4_s16_bist.sv
// March C- self-test controller driving a registered-read 256x16 block RAM port.
module x_ramb4_s16_bist
  import x_ramb4_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  input  logic [DATA_W-1:0] RAM_DO
);

  localparam logic [ADDR_W-1:0] ADDR_MIN = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] bg_word(bg_e b);
    return {DATA_W{b == BG1}};
  endfunction

  state_e            state_q;
  elem_e             elem_q;
  logic              phase_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_di_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic              busy_q;
  logic              done_q;

  elem_cfg_t         cfg_s;
  elem_e             seq_elem_d;
  logic              seq_phase_d;
  logic [ADDR_W-1:0] seq_addr_d;
  logic [ADDR_W-1:0] step_addr_s;
  logic              seq_last_s;
  logic              new_elem_s;
  op_e               nxt_op_s;
  bg_e               nxt_bg_s;
  logic              start_acc_s;

  // Next access after the one on the port: read->write on the same address, then step or change element.
  always_comb begin
    cfg_s       = elem_cfg(elem_q);
    seq_elem_d  = elem_q;
    seq_phase_d = 1'b0;
    step_addr_s = ram_addr_q;
    seq_last_s  = 1'b0;
    new_elem_s  = 1'b0;
    if (cfg_s.two_ops && !phase_q) begin
      seq_phase_d = 1'b1;
    end else if (ram_addr_q == (cfg_s.up ? ADDR_MAX : ADDR_MIN)) begin
      if (elem_q == M5) begin
        seq_last_s = 1'b1;
      end else begin
        seq_elem_d = elem_e'(elem_q + 3'd1);
        new_elem_s = 1'b1;
      end
    end else begin
      step_addr_s = cfg_s.up ? (ram_addr_q + ADDR_ONE) : (ram_addr_q - ADDR_ONE);
    end
    cfg_s = elem_cfg(seq_elem_d);
    if (new_elem_s) begin
      seq_addr_d = cfg_s.up ? ADDR_MIN : ADDR_MAX;
    end else begin
      seq_addr_d = step_addr_s;
    end
    nxt_op_s = seq_phase_d ? cfg_s.op_b : cfg_s.op_a;
    nxt_bg_s = seq_phase_d ? cfg_s.bg_b : cfg_s.bg_a;
  end

  assign start_acc_s = START & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Control FSM and RAM port registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      elem_q     <= M0;
      phase_q    <= 1'b0;
      ram_addr_q <= ADDR_MIN;
      ram_di_q   <= {DATA_W{1'b0}};
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (start_acc_s) begin
            state_q    <= ST_RUN;
            elem_q     <= M0;
            phase_q    <= 1'b0;
            ram_addr_q <= ADDR_MIN;
            ram_di_q   <= bg_word(BG0);
            ram_en_q   <= 1'b1;
            ram_we_q   <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (seq_last_s) begin
            state_q  <= ST_DRAIN;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
          end else begin
            elem_q     <= seq_elem_d;
            phase_q    <= seq_phase_d;
            ram_addr_q <= seq_addr_d;
            ram_di_q   <= bg_word(nxt_bg_s);
            ram_en_q   <= 1'b1;
            ram_we_q   <= (nxt_op_s == OP_WR);
          end
        end
        ST_DRAIN: begin
          state_q  <= ST_DONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // On reads RAM_DI carries the expected background, so it doubles as the compare value.
  x_ramb4_bist_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .CLK         (CLK),
    .RST         (RST),
    .clr_i       (start_acc_s),
    .issue_i     (ram_en_q & ~ram_we_q),
    .exp_i       (ram_di_q),
    .addr_i      (ram_addr_q),
    .ram_do_i    (RAM_DO),
    .fail_o      (FAIL),
    .fail_addr_o (FAIL_ADDR),
    .fail_data_o (FAIL_DATA)
  );

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;
  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = ram_we_q;
  assign RAM_RST  = 1'b0;

endmodule

// File: tb/tb_x_ramb4_s16_bist.sv
// Directed bench for x_ramb4_s16_bist with a write-first registered-read RAM model and fault injection.
module tb_x_ramb4_s16_bist;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        BUSY, DONE, FAIL, RAM_EN, RAM_WE, RAM_RST;
  logic [7:0]  FAIL_ADDR, RAM_ADDR;
  logic [15:0] FAIL_DATA, RAM_DI, RAM_DO;

  logic [15:0] mem [0:255];
  logic        fault_sa;
  logic        fault_alias;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int busy_cnt = 0;

  always #5 CLK = ~CLK;

  x_ramb4_s16_bist #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FAIL      (FAIL),
    .FAIL_ADDR (FAIL_ADDR),
    .FAIL_DATA (FAIL_DATA),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DI    (RAM_DI),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_RST   (RAM_RST),
    .RAM_DO    (RAM_DO)
  );

  // RAM model: bit 3 of 0x5A reads as 1, or writes to 0x10 also land on 0x90.
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        mem[RAM_ADDR] <= RAM_DI;
        if (fault_alias && RAM_ADDR == 8'h10) mem[8'h90] <= RAM_DI;
        RAM_DO <= RAM_DI;
      end else begin
        RAM_DO <= mem[RAM_ADDR] | ((fault_sa && RAM_ADDR == 8'h5A) ? 16'h0008 : 16'h0000);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RAM_EN) en_cnt++;
      if (BUSY) busy_cnt++;
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick_n(1);
  endtask

  // START high across edge E0; returns sampling cycle 1.
  task automatic start_run();
    START = 1'b1;
    cyc = 0;
    en_cnt = 0;
    busy_cnt = 0;
    tick_n(1);
    START = 1'b0;
  endtask

  task automatic finish_run(input logic exp_fail, input logic [7:0] exp_addr, input logic [15:0] exp_data);
    tick_to(2561);
    chk("drain_busy", BUSY, 1);
    chk("drain_done", DONE, 0);
    tick_to(2562);
    chk("end_busy", BUSY, 0);
    chk("end_done", DONE, 1);
    chk("end_fail", FAIL, exp_fail);
    chk("end_fail_addr", FAIL_ADDR, exp_addr);
    chk("end_fail_data", FAIL_DATA, exp_data);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    fault_sa = 1'b0;
    fault_alias = 1'b0;
    tick_n(3);
    RST = 1'b0;

    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_fail", FAIL, 0);
    chk("rst_en_we", {RAM_EN, RAM_WE, RAM_RST}, 3'b000);
    chk("rst_addrs", {FAIL_ADDR, RAM_ADDR}, 16'h0000);
    chk("rst_datas", {FAIL_DATA, RAM_DI}, 32'h0000_0000);

    // Fault-free run with ignored START pulses at cycles 5 and 2000.
    start_run();
    chk("c1_port", {BUSY, RAM_EN, RAM_WE, RAM_ADDR}, {3'b111, 8'h00});
    chk("c1_di", RAM_DI, 16'h0000);
    tick_to(5);
    START = 1'b1;
    tick_n(1);
    START = 1'b0;
    chk("c6_addr_no_restart", {RAM_WE, RAM_ADDR}, {1'b1, 8'h05});
    tick_to(257);
    chk("m1_first_rd", {RAM_EN, RAM_WE, RAM_ADDR, RAM_DI}, {2'b10, 8'h00, 16'h0000});
    tick_to(258);
    chk("m1_first_wr", {RAM_WE, RAM_ADDR, RAM_DI}, {1'b1, 8'h00, 16'hFFFF});
    tick_to(1281);
    chk("m3_first_rd", {RAM_WE, RAM_ADDR, RAM_DI}, {1'b0, 8'hFF, 16'h0000});
    tick_to(1283);
    chk("m3_step_down", {RAM_WE, RAM_ADDR}, {1'b0, 8'hFE});
    tick_to(2000);
    START = 1'b1;
    tick_n(1);
    START = 1'b0;
    chk("c2001_m4", {BUSY, RAM_WE, RAM_ADDR, RAM_DI}, {2'b10, 8'h97, 16'hFFFF});
    tick_to(2305);
    chk("m5_first_rd", {RAM_WE, RAM_ADDR}, {1'b0, 8'h00});
    tick_to(2560);
    chk("last_access", {RAM_EN, RAM_WE, RAM_ADDR}, {2'b10, 8'hFF});
    finish_run(1'b0, 8'h00, 16'h0000);
    chk("en_cycles", en_cnt, 2560);
    chk("busy_cycles", busy_cnt, 2561);
    chk("done_port_idle", {RAM_EN, RAM_WE, RAM_ADDR}, {2'b00, 8'hFF});

    // Stuck-at-1 on bit 3 of 0x5A.
    fault_sa = 1'b1;
    start_run();
    finish_run(1'b1, 8'h5A, 16'h0008);

    // Fault removed; START from DONE clears the result.
    fault_sa = 1'b0;
    start_run();
    chk("clr_fail", FAIL, 0);
    chk("clr_fail_addr_data", {FAIL_ADDR, FAIL_DATA}, 24'h000000);
    chk("clr_done", DONE, 0);
    finish_run(1'b0, 8'h00, 16'h0000);

    // Address aliasing 0x10 -> 0x90.
    fault_alias = 1'b1;
    start_run();
    finish_run(1'b1, 8'h90, 16'hFFFF);

    // Reset in the middle of a failing run.
    start_run();
    tick_to(1000);
    chk("pre_rst_fail", FAIL, 1);
    RST = 1'b1;
    tick_n(1);
    RST = 1'b0;
    chk("mid_rst_busy_en", {BUSY, RAM_EN, RAM_WE}, 3'b000);
    chk("mid_rst_done_fail", {DONE, FAIL}, 2'b00);
    chk("mid_rst_fail_addr", FAIL_ADDR, 8'h00);
    fault_alias = 1'b0;
    start_run();
    finish_run(1'b0, 8'h00, 16'h0000);
    chk("rerun_en_cycles", en_cnt, 2560);

    // RST and START together: RST wins.
    RST = 1'b1;
    START = 1'b1;
    tick_n(1);
    RST = 1'b0;
    START = 1'b0;
    chk("rst_start_busy", {BUSY, RAM_EN}, 2'b00);
    chk("rst_start_done", DONE, 0);
    tick_n(2);
    chk("rst_start_idle", {BUSY, DONE, RAM_EN}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_ramb4_s16_bist.md
# x_ramb4_s16_bist

March C- built-in self-test controller for one 256x16 single-port block RAM with a registered read port (X_RAMB4_S16 class primitive). It is the initiator on the RAM port: it drives ADDR/DI/EN/WE and checks DO. It sits between the RAM and the system control logic. It owns the RAM port while BUSY is high and reports pass/fail with the first failing location.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (depth = 2**ADDR_W)
- DATA_W, 16, RAM data width

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle run request; sampled only in IDLE or DONE
- BUSY  out  1  test in progress
- DONE  out  1  test finished; held until next START or RST
- FAIL  out  1  sticky mismatch flag for the current run
- FAIL_ADDR  out  ADDR_W  address of the first mismatch
- FAIL_DATA  out  DATA_W  DO value observed at the first mismatch
- RAM_ADDR  out  ADDR_W  to RAM ADDR
- RAM_DI  out  DATA_W  to RAM DI
- RAM_EN  out  1  to RAM EN
- RAM_WE  out  1  to RAM WE
- RAM_RST  out  1  to RAM RST; constant 0
- RAM_DO  in  DATA_W  from RAM DO

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE --START--> RUN. DONE --START--> RUN, clearing DONE, FAIL, FAIL_ADDR and FAIL_DATA. RUN --last access--> DRAIN. DRAIN --> DONE (one cycle).
- START is ignored in RUN and DRAIN.
- March elements, in this order. "0" = all-zero background, "1" = all-one background.
  - M0: up, w0
  - M1: up, r0 then w1
  - M2: up, r1 then w0
  - M3: down, r0 then w1
  - M4: down, r1 then w0
  - M5: up, r0
- "Up" means address 0 to 255; "down" means 255 to 0. The address counter wraps between elements without skipping an address.
- Each read or write is one RAM_EN=1 cycle. Within an r/w element, the write to address A immediately follows the read of A.
- Read check: a read issued in cycle N is compared in cycle N+1. In that cycle RAM_DO is compared against the expected value carried in a one-stage pipeline register, together with the read address.
- On mismatch with FAIL=0: set FAIL, capture FAIL_ADDR and FAIL_DATA=RAM_DO. Later mismatches are ignored. The test always runs to completion.
- RAM_EN=0 and RAM_WE=0 in IDLE, DRAIN and DONE. RAM_ADDR and RAM_DI hold their last values.

## Timing
- Reset values: BUSY, DONE, FAIL, RAM_EN, RAM_WE, RAM_RST = 0. FAIL_ADDR, RAM_ADDR = 0. FAIL_DATA, RAM_DI = 0. State = IDLE. The compare pipeline valid bit is cleared.
- Cycle numbering: START is sampled at edge E0.
  - BUSY=1 and the first access (w0 @0) are present in cycle 1.
  - Access count: 256 + 4x512 + 256 = 2560, occupying cycles 1..2560.
  - The last compare occurs in cycle 2561 (DRAIN).
  - From cycle 2562: BUSY=0, DONE=1, and FAIL/FAIL_ADDR/FAIL_DATA are final.
- Outputs are registered; there is no combinational path from RAM_DO to any output.
- A read followed by a write to the same address is safe. The compare samples RAM_DO before the write edge updates it, which it does under write-first behaviour.
- RST during RUN or DRAIN:
  - Next cycle: all outputs at reset values, RAM_EN=0.
  - The in-flight compare is discarded.
  - Any partial result is lost.
- RST and START in the same cycle: RST wins.

## Structure
- Package x_ramb4_bist_pkg holds:
  - state enum
  - march element enum (M0..M5)
  - op enum (RD, WR)
  - BG0 = all-zero and BG1 = all-one background constants
  - per-element direction/op-sequence lookup function
- Sub-module x_ramb4_bist_chk: one-stage compare pipeline (valid, expected data, address) and first-fail capture registers. It exposes a clear input for START.
- Top level: FSM, element and phase sequencer, up/down address counter, RAM port registers.

## Test plan
Bench uses a behavioural 256x16 registered-read, write-first RAM model with fault injection.
- Fault-free RAM, START pulse -> BUSY cycles 1..2561; DONE=1 at cycle 2562; FAIL=0; exactly 2560 RAM_EN cycles.
- Bit 3 of address 0x5A stuck-at-1 -> FAIL=1, FAIL_ADDR=0x5A, FAIL_DATA=16'h0008 (caught by M1 r0).
- Aliasing fault: a write to 0x10 also writes 0x90 -> FAIL_ADDR=0x90, FAIL_DATA=16'hFFFF.
- RST asserted at cycle 1000 -> next cycle: BUSY=0, RAM_EN=0, DONE=0, FAIL=0. A new START then completes normally 2562 cycles later.
- START pulses at cycles 5 and 2000 -> ignored; DONE still at cycle 2562.
- Faulty run then fault removed and START issued in DONE -> FAIL, FAIL_ADDR and FAIL_DATA cleared the cycle after START; second run ends with FAIL=0.
